// File: rtl/rns_pkg.sv
// rtl/rns_pkg.sv - shared widths and clear-FSM state type for the RNS register file
package rns_pkg;
    localparam int NUM_DOMAINS_DEF = 3;
    localparam int DOMAIN_W_DEF    = 8;
    localparam int WORD_W_DEF      = NUM_DOMAINS_DEF * DOMAIN_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;
endpackage

// File: rtl/rns_reg_lane.sv
// rtl/rns_reg_lane.sv - one residue lane: register array with write, clear and bypassed registered reads
module rns_reg_lane
    import rns_pkg::*;
#(
    parameter int DOMAIN_W = DOMAIN_W_DEF,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DOMAIN_W-1:0] wr_data,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    input  logic [ADDR_W-1:0]   rd_addr1,
    input  logic [ADDR_W-1:0]   rd_addr2,
    output logic [DOMAIN_W-1:0] rd_data1,
    output logic [DOMAIN_W-1:0] rd_data2
);
    logic [DOMAIN_W-1:0] mem_q [NUM_REGS];
    logic [DOMAIN_W-1:0] mem_d [NUM_REGS];
    logic [DOMAIN_W-1:0] rd_data1_q, rd_data1_d;
    logic [DOMAIN_W-1:0] rd_data2_q, rd_data2_d;

    // Reads see the post-update array, which gives write-first and clear-first bypass.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        if (clr_en) begin
            mem_d[clr_addr] = '0;
        end
        rd_data1_d = mem_d[rd_addr1];
        rd_data2_d = mem_d[rd_addr2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q      <= '{default: '0};
            rd_data1_q <= '0;
            rd_data2_q <= '0;
        end else begin
            mem_q      <= mem_d;
            rd_data1_q <= rd_data1_d;
            rd_data2_q <= rd_data2_d;
        end
    end

    assign rd_data1 = rd_data1_q;
    assign rd_data2 = rd_data2_q;
endmodule

// File: rtl/rns_reg_file.sv
// rtl/rns_reg_file.sv - multi-domain RNS register file with pending scoreboard and sequential clear
module rns_reg_file
    import rns_pkg::*;
#(
    parameter int NUM_DOMAINS = NUM_DOMAINS_DEF,
    parameter int DOMAIN_W    = DOMAIN_W_DEF,
    parameter int NUM_REGS    = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [$clog2(NUM_REGS)-1:0]       rd_addr1,
    input  logic [$clog2(NUM_REGS)-1:0]       rd_addr2,
    output logic [NUM_DOMAINS*DOMAIN_W-1:0]   rd_data1,
    output logic [NUM_DOMAINS*DOMAIN_W-1:0]   rd_data2,
    output logic                              rd_pend1,
    output logic                              rd_pend2,
    input  logic                              wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]       wr_addr,
    input  logic [NUM_DOMAINS-1:0]            wr_lane_en,
    input  logic [NUM_DOMAINS*DOMAIN_W-1:0]   wr_data,
    input  logic                              rsv_en,
    input  logic [$clog2(NUM_REGS)-1:0]       rsv_addr,
    input  logic                              clr_req,
    output logic                              clr_busy
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    clr_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                rd_pend1_q, rd_pend1_d;
    logic                rd_pend2_q, rd_pend2_d;
    logic                wr_ok, rsv_ok, clr_en;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        wr_ok   = 1'b0;
        rsv_ok  = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_ok  = wr_en;
                rsv_ok = rsv_en;
                if (clr_req) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                idx_d  = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            end
        endcase
        // Reserve is applied after the write so it wins on a same-address collision.
        if (wr_ok) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_d[rsv_addr] = 1'b1;
        end
        if (clr_en) begin
            pend_d[idx_q] = 1'b0;
        end
        rd_pend1_d = pend_d[rd_addr1];
        rd_pend2_d = pend_d[rd_addr2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= '0;
            rd_pend1_q <= 1'b0;
            rd_pend2_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            rd_pend1_q <= rd_pend1_d;
            rd_pend2_q <= rd_pend2_d;
        end
    end

    for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_lane
        rns_reg_lane #(
            .DOMAIN_W (DOMAIN_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_ok & wr_lane_en[g]),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data[g*DOMAIN_W +: DOMAIN_W]),
            .clr_en   (clr_en),
            .clr_addr (idx_q),
            .rd_addr1 (rd_addr1),
            .rd_addr2 (rd_addr2),
            .rd_data1 (rd_data1[g*DOMAIN_W +: DOMAIN_W]),
            .rd_data2 (rd_data2[g*DOMAIN_W +: DOMAIN_W])
        );
    end

    assign rd_pend1 = rd_pend1_q;
    assign rd_pend2 = rd_pend2_q;
    assign clr_busy = (state_q == CLEAR);
endmodule
